// File: rtl/wdg_pkg.sv
// Purpose : shared definitions for the watchdog kicker (WDCSR field layout,
//           counter register offset, controller state encoding).
// Ports   : none (package).
package wdg_pkg;

  // WDCSR bit layout: enable in bit 0, timeout count in bits 13:4.
  localparam int WDCSR_EN_BIT     = 0;
  localparam int WDCSR_WTOCNT_LSB = 4;
  localparam int WDCSR_WTOCNT_MSB = 13;
  localparam int WDCSR_WTOCNT_W   = WDCSR_WTOCNT_MSB - WDCSR_WTOCNT_LSB + 1;

  // Byte offset of the watchdog counter register from WDCSR.
  localparam int WDG_CNT_OFFSET = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4
  } wdg_state_e;

endpackage

// File: rtl/wdg_kicker.sv
// Purpose : periodically (or on request) rewrites WDCSR over pipelined Wishbone,
//           then reads back the watchdog counter and reports it on o_cnt.
// Latency : kick request -> strobe 1 cycle; read ack -> o_cnt/o_cnt_vld 1 cycle.
// Backpr. : strobe held with stable adr/dat while i_wb_stall=1; waits up to
//           ACK_TIMEOUT cycles for ack, aborting with o_err on timeout or i_wb_err.
// Ports   : clk/res_n (sync, active-low); i_en/i_kick kick control;
//           o_wb_* / i_wb_* Wishbone master; o_busy, o_cnt/o_cnt_vld, o_err status.
module wdg_kicker
  import wdg_pkg::*;
#(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned WDG_BASE      = 0,
  parameter int unsigned KICK_PERIOD   = 64,
  parameter logic [WDCSR_WTOCNT_W-1:0] WTOCNT = 10'h10,
  parameter int unsigned ACK_TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     i_en,
  input  logic                     i_kick,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  input  logic                     i_wb_stall,
  output logic [WB_ADDR_WIDTH-1:0] o_wb_adr,
  output logic                     o_wb_we,
  output logic [WB_DATA_WIDTH-1:0] o_wb_dat,
  output logic [3:0]               o_wb_sel,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic [WB_DATA_WIDTH-1:0] i_wb_dat,
  output logic                     o_busy,
  output logic [WB_DATA_WIDTH-1:0] o_cnt,
  output logic                     o_cnt_vld,
  output logic                     o_err
);

  localparam int unsigned PW = (KICK_PERIOD > 1) ? $clog2(KICK_PERIOD) : 1;
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(KICK_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  localparam logic [WB_ADDR_WIDTH-1:0] WR_ADR = WB_ADDR_WIDTH'(WDG_BASE);
  localparam logic [WB_ADDR_WIDTH-1:0] RD_ADR = WB_ADDR_WIDTH'(WDG_BASE + WDG_CNT_OFFSET);
  localparam logic [WB_DATA_WIDTH-1:0] WR_WORD =
      (WB_DATA_WIDTH'(WTOCNT) << WDCSR_WTOCNT_LSB) | (WB_DATA_WIDTH'(1) << WDCSR_EN_BIT);

  wdg_state_e               state_q, state_d;
  logic [PW-1:0]            per_cnt_q, per_cnt_d;
  logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
  logic                     pend_q, pend_d;
  logic                     cyc_q, cyc_d;
  logic                     stb_q, stb_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [3:0]               sel_q, sel_d;
  logic                     busy_q, busy_d;
  logic [WB_DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                     cnt_vld_q, cnt_vld_d;
  logic                     err_q, err_d;
  logic                     wr_phase, rd_phase;

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    cnt_vld_d = 1'b0;
    err_d     = 1'b0;

    // Kicks arriving mid-transaction collapse into one pending request.
    if (state_q != ST_IDLE && i_kick) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!i_en) begin
          per_cnt_d = '0;
        end else if (pend_q || i_kick || per_cnt_q == PER_LAST) begin
          // Timer expiry, a fresh kick and a pending kick all merge into one.
          state_d   = ST_WR_REQ;
          per_cnt_d = '0;
          tmo_cnt_d = '0;
          pend_d    = 1'b0;
        end else begin
          per_cnt_d = per_cnt_q + 1'b1;
        end
      end

      ST_WR_REQ: begin
        if (i_wb_err) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (!i_wb_stall) begin
          // An ack alongside acceptance completes the write immediately.
          if (i_wb_ack) begin
            state_d   = ST_RD_REQ;
            tmo_cnt_d = '0;
          end else begin
            state_d = ST_WR_WAIT;
          end
        end
      end

      ST_WR_WAIT: begin
        if (i_wb_err) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (i_wb_ack) begin
          state_d   = ST_RD_REQ;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_RD_REQ: begin
        if (i_wb_err) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (!i_wb_stall) begin
          if (i_wb_ack) begin
            state_d   = ST_IDLE;
            cnt_d     = i_wb_dat;
            cnt_vld_d = 1'b1;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        if (i_wb_err) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (i_wb_ack) begin
          state_d   = ST_IDLE;
          cnt_d     = i_wb_dat;
          cnt_vld_d = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from the next state so they are registered
  // alongside it and line up with the state they describe.
  always_comb begin
    wr_phase = (state_d == ST_WR_REQ) || (state_d == ST_WR_WAIT);
    rd_phase = (state_d == ST_RD_REQ) || (state_d == ST_RD_WAIT);
    cyc_d    = wr_phase || rd_phase;
    stb_d    = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
    we_d     = wr_phase;
    adr_d    = wr_phase ? WR_ADR : (rd_phase ? RD_ADR : '0);
    dat_d    = wr_phase ? WR_WORD : '0;
    sel_d    = cyc_d ? 4'hF : 4'h0;
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q   <= ST_IDLE;
      per_cnt_q <= '0;
      tmo_cnt_q <= '0;
      pend_q    <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      cnt_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      pend_q    <= pend_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      cnt_vld_q <= cnt_vld_d;
      err_q     <= err_d;
    end
  end

  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = dat_q;
  assign o_wb_sel  = sel_q;
  assign o_busy    = busy_q;
  assign o_cnt     = cnt_q;
  assign o_cnt_vld = cnt_vld_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_wdg_kicker.sv
module tb_wdg_kicker;

  localparam int KP       = 64;
  localparam int TMO      = 16;
  localparam logic [31:0] WR_ADR  = 32'h0000_0000;
  localparam logic [31:0] RD_ADR  = 32'h0000_0004;
  localparam logic [31:0] WR_WORD = 32'h0000_0101;

  logic        clk = 1'b0;
  logic        res_n;
  logic        i_en, i_kick;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic        i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0] o_wb_adr, o_wb_dat, i_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_busy, o_cnt_vld, o_err;
  logic [31:0] o_cnt;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int last_idle = 0;
  logic [31:0] exp_cnt = 32'h0;

  // Negedge bus monitor: counts accepted strobes and count-valid pulses.
  int wr_acc = 0;
  int rd_acc = 0;
  int vld_n  = 0;

  wdg_kicker dut (
    .clk(clk), .res_n(res_n), .i_en(i_en), .i_kick(i_kick),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_stall(i_wb_stall),
    .o_wb_adr(o_wb_adr), .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat),
    .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_dat(i_wb_dat), .o_busy(o_busy), .o_cnt(o_cnt),
    .o_cnt_vld(o_cnt_vld), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_wb_stb && !i_wb_stall) begin
      if (o_wb_we) wr_acc++;
      else rd_acc++;
    end
    if (o_cnt_vld) vld_n++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Bounded wait for the next write strobe; its arrival cycle is compared to the model.
  task automatic wait_stb(input string tag, input int exp_at);
    int n;
    n = 0;
    while (o_wb_stb !== 1'b1 && n < 4 * KP) begin
      step();
      n++;
    end
    chk(tag, cyc_n, exp_at);
    chk1({tag, "_we"}, o_wb_we, 1'b1);
  endtask

  // Serve one kick starting at an observed write strobe. wd/rd = cycles from
  // strobe to ack (0 = ack together with acceptance).
  task automatic serve_txn(input int wd, input int rd, input logic [31:0] data);
    chk("wr_adr", o_wb_adr, WR_ADR);
    chk("wr_dat", o_wb_dat, WR_WORD);
    chk("wr_sel", 32'(o_wb_sel), 32'hF);
    chk1("wr_cyc", o_wb_cyc, 1'b1);
    i_wb_ack = 1'b0;
    repeat (wd) step();
    i_wb_ack = 1'b1;
    step();
    i_wb_ack = 1'b0;
    chk("rd_req_ctl", 32'({o_wb_cyc, o_wb_stb, o_wb_we}), 32'h6);
    chk("rd_adr", o_wb_adr, RD_ADR);
    repeat (rd) step();
    i_wb_ack = 1'b1;
    i_wb_dat = data;
    step();
    i_wb_ack = 1'b0;
    exp_cnt = data;
    chk1("rd_vld", o_cnt_vld, 1'b1);
    chk("rd_cnt", o_cnt, exp_cnt);
    chk1("rd_done_cyc", o_wb_cyc, 1'b0);
    chk1("rd_done_busy", o_busy, 1'b0);
    last_idle = cyc_n;
  endtask

  initial begin
    int r, w0, r0, v0, c, k;
    logic [31:0] d;

    res_n = 1'b0; i_en = 1'b0; i_kick = 1'b0;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = 32'h0;

    // Reset state
    repeat (3) step();
    chk1("rst_cyc", o_wb_cyc, 1'b0);
    chk1("rst_stb", o_wb_stb, 1'b0);
    chk1("rst_we", o_wb_we, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_vld", o_cnt_vld, 1'b0);
    chk1("rst_err", o_err, 1'b0);
    chk("rst_adr", o_wb_adr, 32'h0);
    chk("rst_dat", o_wb_dat, 32'h0);
    chk("rst_sel", 32'(o_wb_sel), 32'h0);
    chk("rst_cnt", o_cnt, 32'h0);
    i_en = 1'b1;
    step();
    chk1("rst_en_busy", o_busy, 1'b0);

    // First kick KP cycles after release, slave acks one cycle after each strobe
    res_n = 1'b1;
    r = cyc_n;
    wait_stb("first_kick_at", r + KP);
    v0 = vld_n;
    serve_txn(1, 1, $urandom);
    step();
    chk("first_single_vld", vld_n - v0, 1);
    chk1("first_vld_low", o_cnt_vld, 1'b0);

    // Stall for 5 cycles: strobe and payload held, one write accepted
    i_wb_stall = 1'b1;
    wait_stb("stall_kick_at", last_idle + KP);
    w0 = wr_acc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("stall_stb", o_wb_stb, 1'b1);
      chk("stall_adr", o_wb_adr, WR_ADR);
      chk("stall_dat", o_wb_dat, WR_WORD);
    end
    i_wb_stall = 1'b0;
    serve_txn(0, 0, $urandom);
    chk("stall_one_wr", wr_acc - w0, 1);

    // Slave never acks: error after TMO cycles in the wait state
    wait_stb("tmo_kick_at", last_idle + KP);
    step();
    chk("tmo_wait_ctl", 32'({o_wb_cyc, o_wb_stb}), 32'h2);
    repeat (TMO - 1) step();
    chk1("tmo_early_err", o_err, 1'b0);
    chk1("tmo_early_cyc", o_wb_cyc, 1'b1);
    step();
    chk1("tmo_err", o_err, 1'b1);
    chk1("tmo_cyc", o_wb_cyc, 1'b0);
    chk("tmo_cnt_kept", o_cnt, exp_cnt);
    last_idle = cyc_n;
    step();
    chk1("tmo_err_pulse", o_err, 1'b0);

    // Two kicks during the write wait collapse into one follow-up kick
    wait_stb("pend_kick_at", last_idle + KP);
    step();
    repeat ($urandom_range(0, 2)) step();
    i_kick = 1'b1; step(); i_kick = 1'b0;
    repeat ($urandom_range(0, 2)) step();
    i_kick = 1'b1; step(); i_kick = 1'b0;
    i_wb_ack = 1'b1;
    step();
    d = $urandom;
    i_wb_dat = d;
    step();
    i_wb_ack = 1'b0;
    exp_cnt = d;
    chk1("pend_rd_vld", o_cnt_vld, 1'b1);
    chk("pend_rd_cnt", o_cnt, exp_cnt);
    c = cyc_n;
    wait_stb("pend_extra_at", c + 1);
    serve_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    wait_stb("pend_single", last_idle + KP);

    // Bus error on the write: abort, no read, next kick a full period later
    r0 = rd_acc;
    i_wb_err = 1'b1;
    step();
    i_wb_err = 1'b0;
    chk1("err_pulse", o_err, 1'b1);
    chk1("err_cyc", o_wb_cyc, 1'b0);
    chk1("err_vld", o_cnt_vld, 1'b0);
    chk("err_cnt_kept", o_cnt, exp_cnt);
    last_idle = cyc_n;
    wait_stb("err_next_at", last_idle + KP);
    chk("err_no_read", rd_acc - r0, 0);

    // Reset while waiting for the read ack
    i_wb_ack = 1'b1;
    step();
    i_wb_ack = 1'b0;
    step();
    chk("rdw_ctl", 32'({o_wb_cyc, o_wb_stb, o_wb_we, o_busy}), 32'h9);
    res_n = 1'b0;
    i_wb_ack = 1'b1;
    i_wb_dat = $urandom;
    step();
    i_wb_ack = 1'b0;
    chk1("rdw_rst_cyc", o_wb_cyc, 1'b0);
    chk1("rdw_rst_stb", o_wb_stb, 1'b0);
    chk1("rdw_rst_busy", o_busy, 1'b0);
    chk1("rdw_rst_vld", o_cnt_vld, 1'b0);
    exp_cnt = 32'h0;
    chk("rdw_rst_cnt", o_cnt, exp_cnt);
    res_n = 1'b1;
    r = cyc_n;
    // Ack/err while idle are ignored
    i_wb_ack = 1'b1; i_wb_err = 1'b1;
    step();
    i_wb_ack = 1'b0; i_wb_err = 1'b0;
    chk1("idle_ack_err", o_err, 1'b0);
    chk1("idle_ack_vld", o_cnt_vld, 1'b0);
    wait_stb("rerst_kick_at", r + KP);

    // Randomized slave latencies against the periodic-kick model
    for (int i = 0; i < 3; i++) begin
      serve_txn($urandom_range(0, 6), $urandom_range(0, 6), $urandom);
      wait_stb("rand_kick_at", last_idle + KP);
    end

    // Kick coinciding with timer expiry yields a single kick
    serve_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    repeat (KP - 1) step();
    i_kick = 1'b1; step(); i_kick = 1'b0;
    chk("coinc_at", cyc_n, last_idle + KP);
    chk1("coinc_stb", o_wb_stb, 1'b1);
    serve_txn(1, 1, $urandom);
    wait_stb("coinc_single", last_idle + KP);

    // Immediate kick in idle restarts the period
    serve_txn(0, 1, $urandom);
    k = $urandom_range(1, KP - 3);
    repeat (k) step();
    i_kick = 1'b1; step(); i_kick = 1'b0;
    chk1("imm_kick_stb", o_wb_stb, 1'b1);
    serve_txn(1, 0, $urandom);
    wait_stb("imm_next_at", last_idle + KP);

    // Disable mid-transaction: completes, then stays idle
    i_en = 1'b0;
    serve_txn(2, 2, $urandom);
    w0 = wr_acc;
    repeat (2 * KP) step();
    chk("en_off_no_kick", wr_acc - w0, 0);
    chk1("en_off_busy", o_busy, 1'b0);
    i_kick = 1'b1; step(); i_kick = 1'b0;
    step();
    chk1("en_off_kick_ign", o_wb_stb, 1'b0);
    i_en = 1'b1;
    r = cyc_n;
    wait_stb("reen_kick_at", r + KP);
    serve_txn(0, 0, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
